// File: rtl/cp0_exc_ctrl_pkg.sv
// ============================================================================
// cp0_exc_ctrl_pkg : shared exception codes, CP0 register map and write masks
// Revision: 1.0
// ============================================================================
`default_nettype none

package cp0_exc_ctrl_pkg;

  // Exception codes carried down the pipeline
  localparam logic [4:0] INT    = 5'd0;
  localparam logic [4:0] ADEL   = 5'd4;
  localparam logic [4:0] ADES   = 5'd5;
  localparam logic [4:0] RI     = 5'd10;
  localparam logic [4:0] OV     = 5'd12;
  localparam logic [4:0] NO_EXC = 5'h1F;

  // CP0 register indices
  localparam logic [4:0] SR    = 5'd12;
  localparam logic [4:0] CAUSE = 5'd13;
  localparam logic [4:0] EPC   = 5'd14;
  localparam logic [4:0] PRID  = 5'd15;

  localparam logic [31:0] IM_INIT          = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL_DEF     = 32'h4D49_5053;

  // Implemented bits of each writable register
  localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [31:0] EPC_WMASK = 32'hFFFF_FFFC;

  // Field positions
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LSB    = 10;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_LSB = 10;
  localparam int CAUSE_EC_LSB = 2;

  // Effective controller state is SR.EXL
  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  function automatic logic cp0_writable(input logic [4:0] addr);
    return (addr == SR) || (addr == EPC);
  endfunction

  function automatic logic [31:0] cp0_wmask(input logic [4:0] addr, input logic [31:0] data);
    case (addr)
      SR:      return data & SR_WMASK;
      EPC:     return data & EPC_WMASK;
      default: return 32'h0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_int_arb.sv
// ============================================================================
// cp0_int_arb : combinational interrupt/exception request arbiter and EPC calc
// Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_int_arb
  import cp0_exc_ctrl_pkg::*;
(
  input  logic [5:0]  hw_int,
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [4:0]  exc_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  output logic        take,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_val
);

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_epc_raw;

  always_comb begin
    w_int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    w_exc_req = (exc_m != NO_EXC) & ~sr_exl;
    take      = w_int_req | w_exc_req;
    // Interrupts win over a synchronous exception arriving in the same cycle
    exc_code  = w_int_req ? INT : exc_m;
    // A delay-slot victim restarts at its branch; wrap-around is harmless
    w_epc_raw = bd_m ? (pc_m - 32'd4) : pc_m;
    epc_val   = w_epc_raw & EPC_WMASK;
  end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// cp0_exc_ctrl : M-stage CP0 exception/interrupt controller (SR/Cause/EPC/PRId)
// Optional: define CP0_RD_BYPASS_EN to forward same-cycle mtc0 data to mfc0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] PRID_VAL     = PRID_VAL_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        we,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic [31:0] rd_data,
  output logic        if_handler,
  output logic [31:0] handler_pc,
  output logic        flush,
  output logic        exl
);

  logic [31:0] sr_q,    sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;

  logic        w_take;
  logic [4:0]  w_exc_code;
  logic [31:0] w_epc_val;
  logic [0:0]  w_state;

  cp0_int_arb u_arb (
    .hw_int   (hw_int),
    .sr_im    (sr_q[SR_IM_LSB +: 6]),
    .sr_ie    (sr_q[SR_IE_BIT]),
    .sr_exl   (sr_q[SR_EXL_BIT]),
    .exc_m    (exc_m),
    .pc_m     (pc_m),
    .bd_m     (bd_m),
    .take     (w_take),
    .exc_code (w_exc_code),
    .epc_val  (w_epc_val)
  );

  assign w_state = sr_q[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      sr_q    <= 32'h0;
      cause_q <= 32'h0;
      epc_q   <= 32'h0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state logic
  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cause_d[CAUSE_IP_LSB +: 6] = hw_int;
    if (w_take) begin
      // Taking a request discards any mtc0 and eret in the same cycle
      sr_d[SR_EXL_BIT]           = 1'b1;
      cause_d[CAUSE_EC_LSB +: 5] = w_exc_code;
      cause_d[CAUSE_BD_BIT]      = bd_m;
      epc_d                      = w_epc_val;
    end else begin
      if (we && (wr_addr == SR))
        sr_d = cp0_wmask(SR, wr_data);
      if (we && (wr_addr == EPC))
        epc_d = cp0_wmask(EPC, wr_data);
      if (eret_m && (w_state == ST_HANDLER))
        sr_d[SR_EXL_BIT] = 1'b0;
      else if (eret_m)
        sr_d[SR_EXL_BIT] = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    if_handler = 1'b0;
    flush      = 1'b0;
    handler_pc = HANDLER_ADDR;
    exl        = sr_q[SR_EXL_BIT];
    if (!Reset) begin
      if (w_take) begin
        if_handler = 1'b1;
        flush      = 1'b1;
      end else if (eret_m) begin
        if_handler = 1'b1;
        flush      = 1'b1;
        handler_pc = epc_q;
      end
    end

    case (rd_addr)
      SR:      rd_data = sr_q;
      CAUSE:   rd_data = cause_q;
      EPC:     rd_data = epc_q;
      PRID:    rd_data = PRID_VAL;
      default: rd_data = 32'h0;
    endcase
`ifdef CP0_RD_BYPASS_EN
    if (we && !w_take && (rd_addr == wr_addr) && cp0_writable(wr_addr))
      rd_data = cp0_wmask(wr_addr, wr_data);
`else
    if (cp0_writable(rd_addr) && (rd_addr == PRID))
      rd_data = PRID_VAL;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// tb_cp0_exc_ctrl : table-driven, scoreboarded bench for cp0_exc_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;
  import cp0_exc_ctrl_pkg::*;

  localparam logic [31:0] H = 32'h0000_4180;

  typedef struct {
    logic        rst;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic [31:0] erd;
    logic        eifh;
    logic [31:0] ehpc;
    logic        efl;
    logic        eexl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_m;
  logic [31:0] wr_data, pc_m;
  logic        we, bd_m, eret_m;
  logic [5:0]  hw_int;
  logic [31:0] rd_data, handler_pc;
  logic        if_handler, flush, exl;

  int   errors = 0;
  int   checks = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .Reset      (reset),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_m      (exc_m),
    .eret_m     (eret_m),
    .hw_int     (hw_int),
    .rd_data    (rd_data),
    .if_handler (if_handler),
    .handler_pc (handler_pc),
    .flush      (flush),
    .exl        (exl)
  );

  function automatic vec_t vec(input logic rst, input logic [4:0] rd, input logic w,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                               input logic eret, input logic [5:0] hw,
                               input logic [31:0] erd, input logic eifh,
                               input logic [31:0] ehpc, input logic efl, input logic eexl);
    vec_t v;
    v.rst = rst; v.rd = rd; v.we = w; v.wa = wa; v.wd = wd; v.pc = pc; v.bd = bd;
    v.exc = exc; v.eret = eret; v.hw = hw;
    v.erd = erd; v.eifh = eifh; v.ehpc = ehpc; v.efl = efl; v.eexl = eexl;
    return v;
  endfunction

  // Quiet read cycle: no request, no redirect
  function automatic vec_t rdv(input logic [4:0] rd, input logic [31:0] erd, input logic eexl);
    return vec(1'b0, rd, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, NO_EXC, 1'b0, 6'd0,
               erd, 1'b0, H, 1'b0, eexl);
  endfunction

  function automatic vec_t eret_v(input logic [31:0] erd, input logic [31:0] epc);
    return vec(1'b0, SR, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, NO_EXC, 1'b1, 6'd0,
               erd, 1'b1, epc, 1'b1, 1'b1);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    reset   = v.rst;   rd_addr = v.rd;  we     = v.we;   wr_addr = v.wa;
    wr_data = v.wd;    pc_m    = v.pc;  bd_m   = v.bd;   exc_m   = v.exc;
    eret_m  = v.eret;  hw_int  = v.hw;
    sb_q.push_back(v);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      e = sb_q.pop_front();
      check("rd_data",    idx, rd_data,            e.erd);
      check("if_handler", idx, {31'd0, if_handler}, {31'd0, e.eifh});
      check("handler_pc", idx, handler_pc,         e.ehpc);
      check("flush",      idx, {31'd0, flush},      {31'd0, e.efl});
      check("exl",        idx, {31'd0, exl},        {31'd0, e.eexl});
    end
  endtask

  initial begin
    reset = 1'b1; rd_addr = 5'd0; we = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    pc_m = 32'h0; bd_m = 1'b0; exc_m = NO_EXC; eret_m = 1'b0; hw_int = 6'd0;
    repeat (2) @(posedge clk);

    // Reset state and PRId
    tbl.push_back(rdv(SR, 32'h0, 1'b0));
    tbl.push_back(rdv(CAUSE, 32'h0, 1'b0));
    tbl.push_back(rdv(EPC, 32'h0, 1'b0));
    tbl.push_back(rdv(PRID, 32'h4D49_5053, 1'b0));
    // Fetch-side AdEL on an unaligned PC
    tbl.push_back(vec(0, CAUSE, 0, 0, 0, 32'h3006, 0, ADEL, 0, 0, 32'h0, 1, H, 1, 0));
    tbl.push_back(rdv(EPC, 32'h3004, 1'b1));
    tbl.push_back(rdv(CAUSE, 32'h10, 1'b1));
    tbl.push_back(rdv(SR, 32'h2, 1'b1));
    // Nested exception ignored while EXL=1
    tbl.push_back(vec(0, EPC, 0, 0, 0, 32'h5000, 0, RI, 0, 0, 32'h3004, 0, H, 0, 1));
    tbl.push_back(rdv(CAUSE, 32'h10, 1'b1));
    tbl.push_back(vec(0, EPC, 0, 0, 0, 0, 0, NO_EXC, 1, 0, 32'h3004, 1, 32'h3004, 1, 1));
    tbl.push_back(rdv(SR, 32'h0, 1'b0));
    // Enable IM[0]/IE, then a hardware interrupt
    tbl.push_back(vec(0, SR, 1, SR, 32'h401, 0, 0, NO_EXC, 0, 0, 32'h0, 0, H, 0, 0));
    tbl.push_back(rdv(SR, 32'h401, 1'b0));
    tbl.push_back(vec(0, CAUSE, 0, 0, 0, 32'h3020, 0, NO_EXC, 0, 6'b000001, 32'h10, 1, H, 1, 0));
    tbl.push_back(vec(0, CAUSE, 0, 0, 0, 0, 0, NO_EXC, 0, 6'b000001, 32'h400, 0, H, 0, 1));
    tbl.push_back(rdv(EPC, 32'h3020, 1'b1));
    tbl.push_back(rdv(CAUSE, 32'h0, 1'b1));
    // Leave the handler by clearing EXL through mtc0
    tbl.push_back(vec(0, SR, 1, SR, 32'h0, 0, 0, NO_EXC, 0, 0, 32'h403, 0, H, 0, 1));
    tbl.push_back(rdv(SR, 32'h0, 1'b0));
    // Delay-slot overflow
    tbl.push_back(vec(0, EPC, 0, 0, 0, 32'h3010, 1, OV, 0, 0, 32'h3020, 1, H, 1, 0));
    tbl.push_back(rdv(CAUSE, 32'h8000_0030, 1'b1));
    tbl.push_back(rdv(EPC, 32'h300C, 1'b1));
    tbl.push_back(eret_v(32'h2, 32'h300C));
    // mtc0 to EPC coincident with a take is dropped
    tbl.push_back(vec(0, EPC, 1, EPC, 32'h5000, 32'h3040, 0, RI, 0, 0, 32'h300C, 1, H, 1, 0));
    tbl.push_back(rdv(EPC, 32'h3040, 1'b1));
    tbl.push_back(rdv(CAUSE, 32'h28, 1'b1));
    tbl.push_back(eret_v(32'h2, 32'h3040));
    // eret ignored when a take happens the same cycle
    tbl.push_back(vec(0, CAUSE, 0, 0, 0, 32'h3050, 0, ADES, 1, 0, 32'h28, 1, H, 1, 0));
    tbl.push_back(rdv(CAUSE, 32'h14, 1'b1));
    // Cause is not writable; EPC write drops low bits
    tbl.push_back(vec(0, CAUSE, 1, CAUSE, 32'hFFFF_FFFF, 0, 0, NO_EXC, 0, 0, 32'h14, 0, H, 0, 1));
    tbl.push_back(rdv(CAUSE, 32'h14, 1'b1));
    tbl.push_back(vec(0, EPC, 1, EPC, 32'h1237, 0, 0, NO_EXC, 0, 0, 32'h3050, 0, H, 0, 1));
    tbl.push_back(rdv(EPC, 32'h1234, 1'b1));
    tbl.push_back(eret_v(32'h2, 32'h1234));
    // Reset coincident with a take
    tbl.push_back(vec(1, SR, 0, 0, 0, 32'h3000, 0, ADEL, 0, 0, 32'h0, 0, H, 0, 0));
    tbl.push_back(rdv(EPC, 32'h0, 1'b0));
    tbl.push_back(rdv(CAUSE, 32'h0, 1'b0));
    tbl.push_back(rdv(SR, 32'h0, 1'b0));
    // pc_m-4 wraps modulo 2^32
    tbl.push_back(vec(0, SR, 0, 0, 0, 32'h0, 1, RI, 0, 0, 32'h0, 1, H, 1, 0));
    tbl.push_back(rdv(EPC, 32'hFFFF_FFFC, 1'b1));
    tbl.push_back(rdv(CAUSE, 32'h8000_0028, 1'b1));

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Interrupt beats an exception raised in the same cycle
    run_vec(eret_v(32'h2, 32'hFFFF_FFFC), 100);
    run_vec(vec(0, SR, 1, SR, 32'h401, 0, 0, NO_EXC, 0, 0, 32'h0, 0, H, 0, 0), 101);
    run_vec(vec(0, CAUSE, 0, 0, 0, 32'h3100, 0, OV, 0, 6'b000001,
                32'h8000_0028, 1, H, 1, 0), 102);
    run_vec(rdv(CAUSE, 32'h400, 1'b1), 103);
    run_vec(rdv(EPC, 32'h3100, 1'b1), 104);
    // Interrupt line outside IM is only reflected in IP
    run_vec(eret_v(32'h403, 32'h3100), 105);
    run_vec(vec(0, CAUSE, 0, 0, 0, 0, 0, NO_EXC, 0, 6'b000010, 32'h0, 0, H, 0, 0), 106);
    run_vec(rdv(CAUSE, 32'h800, 1'b0), 107);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
